// File: rtl/ps2_host_tx_pkg.sv
// PS/2 host transmit shared definitions: FSM encodings and command codes.
// Also imported by the PS/2 receiver.
package ps2_host_tx_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_RTS       = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_ACK       = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] DEV_ACK      = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data pads with a
// falling-edge strobe on the synchronized clock.
module ps2_line_sync (
  input  logic Clock,
  input  logic Reset,
  input  logic iPS2_CLK,
  input  logic iPS2_DATA,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall
);

  logic [2:0] clk_sr;
  logic [1:0] data_sr;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      clk_sr  <= 3'b111;
      data_sr <= 2'b11;
    end else begin
      clk_sr  <= {clk_sr[1:0], iPS2_CLK};
      data_sr <= {data_sr[0], iPS2_DATA};
    end
  end

  assign clk_s    = clk_sr[1];
  assign data_s   = data_sr[1];
  assign clk_fall = clk_sr[2] & ~clk_sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send,
// 11-bit frame shifted on device clock falling edges, ACK check.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 3000,
  parameter int TIMEOUT_CYCLES = 375000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] iData,
  input  logic       iStart,
  input  logic       iPS2_CLK,
  input  logic       iPS2_DATA,
  output logic       oPS2_CLK_LOW,
  output logic       oPS2_DATA_LOW,
  output logic       oBusy,
  output logic       oDone,
  output logic       oError
);

  localparam int CMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                        INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_PRE  = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic          clk_s;
  logic          data_s;
  logic          clk_fall;
  logic [2:0]    state;
  logic [7:0]    data_q;
  logic          par_q;
  logic [3:0]    idx;
  logic [CW-1:0] cnt;
  logic          frame_bit;
  logic          timed;
  logic          to_hit;

  ps2_line_sync u_sync (
    .Clock     (Clock),
    .Reset     (Reset),
    .iPS2_CLK  (iPS2_CLK),
    .iPS2_DATA (iPS2_DATA),
    .clk_s     (clk_s),
    .data_s    (data_s),
    .clk_fall  (clk_fall)
  );

  always_comb begin
    frame_bit = 1'b1;
    if (idx < 4'd8)
      frame_bit = data_q[idx[2:0]];
    else if (idx == 4'd8)
      frame_bit = par_q;
  end

  assign timed  = (state == ST_RTS) || (state == ST_SHIFT) ||
                  (state == ST_ACK) || (state == ST_WAIT_IDLE);
  assign to_hit = timed && !clk_fall && (cnt == TO_LAST);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      data_q        <= '0;
      par_q         <= 1'b0;
      idx           <= '0;
      cnt           <= '0;
      oPS2_CLK_LOW  <= 1'b0;
      oPS2_DATA_LOW <= 1'b0;
      oBusy         <= 1'b0;
      oDone         <= 1'b0;
      oError        <= 1'b0;
    end else begin
      oDone  <= 1'b0;
      oError <= 1'b0;
      if (to_hit) begin
        oPS2_CLK_LOW  <= 1'b0;
        oPS2_DATA_LOW <= 1'b0;
        oError        <= 1'b1;
        oBusy         <= 1'b0;
        cnt           <= '0;
        state         <= ST_IDLE;
      end else begin
        unique case (state)
          ST_IDLE: begin
            oPS2_CLK_LOW  <= 1'b0;
            oPS2_DATA_LOW <= 1'b0;
            if (iStart) begin
              data_q        <= iData;
              par_q         <= odd_parity(iData);
              cnt           <= '0;
              idx           <= '0;
              oBusy         <= 1'b1;
              oPS2_CLK_LOW  <= 1'b1;
              oPS2_DATA_LOW <= (INHIBIT_CYCLES == 1);
              state         <= ST_INHIBIT;
            end
          end
          ST_INHIBIT: begin
            if (cnt == INH_LAST) begin
              oPS2_CLK_LOW <= 1'b0;
              cnt          <= '0;
              state        <= ST_RTS;
            end else begin
              cnt <= cnt + CW'(1);
              if (cnt == INH_PRE)
                oPS2_DATA_LOW <= 1'b1;
            end
          end
          ST_RTS: begin
            if (clk_fall) begin
              oPS2_DATA_LOW <= ~data_q[0];
              idx           <= 4'd1;
              state         <= ST_SHIFT;
            end
          end
          ST_SHIFT: begin
            if (clk_fall) begin
              oPS2_DATA_LOW <= ~frame_bit;
              idx           <= idx + 4'd1;
              if (idx == 4'd9)
                state <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              if (data_s) begin
                oError <= 1'b1;
                oBusy  <= 1'b0;
                state  <= ST_IDLE;
              end else begin
                state <= ST_WAIT_IDLE;
              end
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_s && data_s) begin
              oDone <= 1'b1;
              oBusy <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: begin
            oPS2_CLK_LOW  <= 1'b0;
            oPS2_DATA_LOW <= 1'b0;
            oBusy         <= 1'b0;
            state         <= ST_IDLE;
          end
        endcase
        // Device clock edges restart the inactivity window.
        if (timed)
          cnt <= clk_fall ? '0 : cnt + CW'(1);
      end
    end
  end

endmodule
